// File: rtl/div_pkg.sv
// Shared definitions for the sequential non-restoring divider:
// FSM state encoding and default operand width.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_nr_step.sv
// One non-restoring division step: shift in the next dividend bit, then
// add or subtract the divisor depending on the sign of the partial remainder.
module div_nr_step #(
    parameter int unsigned WIDTH = div_pkg::DIV_WIDTH
) (
    input  logic [WIDTH:0]   pr_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] der_i,
    output logic [WIDTH:0]   pr_o,
    output logic             qbit_o
);

    logic [WIDTH:0] shifted;

    always_comb begin
        shifted = {pr_i[WIDTH-1:0], bit_i};
        if (pr_i[WIDTH]) begin
            pr_o = shifted + {1'b0, der_i};
        end else begin
            pr_o = shifted - {1'b0, der_i};
        end
        qbit_o = ~pr_o[WIDTH];
    end

endmodule

// File: rtl/div_seq.sv
// Sequential 2W/W divider, signed or unsigned, one quotient bit per cycle,
// with divide-by-zero and quotient-overflow detection.
module div_seq
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sgn,
    input  logic [2*WIDTH-1:0] dnd,
    input  logic [WIDTH-1:0]   der,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   quo,
    output logic [WIDTH-1:0]   rem,
    output logic               err,
    output logic               ovf
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   pr_q, pr_d;
    logic [WIDTH-1:0] qw_q, qw_d;
    logic [WIDTH-1:0] der_q, der_d;
    logic             sgn_q, sgn_d;
    logic             dneg_q, dneg_d;
    logic             qneg_q, qneg_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             err_q, err_d;
    logic             ovf_q, ovf_d;

    logic               dnd_neg, der_neg;
    logic [2*WIDTH-1:0] dnd_mag;
    logic [WIDTH-1:0]   der_mag;

    logic [WIDTH:0]   step_pr;
    logic             step_qbit;
    logic [WIDTH-1:0] q_mag, r_mag;
    logic             q_big;

    always_comb begin
        dnd_neg = sgn & dnd[2*WIDTH-1];
        der_neg = sgn & der[WIDTH-1];
        dnd_mag = dnd_neg ? -dnd : dnd;
        der_mag = der_neg ? -der : der;
    end

    div_nr_step #(.WIDTH(WIDTH)) u_step (
        .pr_i   (pr_q),
        .bit_i  (qw_q[WIDTH-1]),
        .der_i  (der_q),
        .pr_o   (step_pr),
        .qbit_o (step_qbit)
    );

    // Remainder correction and sign fix-up are evaluated on the last CALC
    // edge, so the registered results are already valid in the FIX cycle.
    always_comb begin
        q_mag = {qw_q[WIDTH-2:0], step_qbit};
        r_mag = step_pr[WIDTH-1:0] + (step_pr[WIDTH] ? der_q : '0);
        q_big = sgn_q & (qneg_q ? (q_mag[WIDTH-1] & (|q_mag[WIDTH-2:0]))
                                : q_mag[WIDTH-1]);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pr_d    = pr_q;
        qw_d    = qw_q;
        der_d   = der_q;
        sgn_d   = sgn_q;
        dneg_d  = dneg_q;
        qneg_d  = qneg_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        err_d   = err_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sgn_d  = sgn;
                    dneg_d = dnd_neg;
                    qneg_d = dnd_neg ^ der_neg;
                    der_d  = der_mag;
                    pr_d   = {1'b0, dnd_mag[2*WIDTH-1:WIDTH]};
                    qw_d   = dnd_mag[WIDTH-1:0];
                    cnt_d  = '0;
                    quo_d  = '0;
                    rem_d  = '0;
                    err_d  = 1'b0;
                    ovf_d  = 1'b0;
                    if (der == '0) begin
                        err_d   = 1'b1;
                        state_d = ST_FIX;
                    end else if (dnd_mag[2*WIDTH-1:WIDTH] >= der_mag) begin
                        ovf_d   = 1'b1;
                        state_d = ST_FIX;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                pr_d  = step_pr;
                qw_d  = q_mag;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                    if (q_big) begin
                        ovf_d = 1'b1;
                    end else begin
                        quo_d = qneg_q ? -q_mag : q_mag;
                        rem_d = dneg_q ? -r_mag : r_mag;
                    end
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pr_q    <= '0;
            qw_q    <= '0;
            der_q   <= '0;
            sgn_q   <= 1'b0;
            dneg_q  <= 1'b0;
            qneg_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pr_q    <= pr_d;
            qw_q    <= qw_d;
            der_q   <= der_d;
            sgn_q   <= sgn_d;
            dneg_q  <= dneg_d;
            qneg_q  <= qneg_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_FIX);
    assign quo  = quo_q;
    assign rem  = rem_q;
    assign err  = err_q;
    assign ovf  = ovf_q;

endmodule
